// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and widths for the truth-table sweeper
package tt_sweep_pkg;

    localparam int TT_W  = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - clearable up counter flagging the last settle cycle
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/tt_sweeper.sv
// rtl/tt_sweeper.sv - sweeps a 4-input FUT through all codes and checks its truth table
// Optional macro TT_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching code.
module tt_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int N_IN          = 4
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic [TT_W-1:0]  expected,
    output logic [IDX_W-1:0] SW,
    input  logic             LEDR,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TT_W-1:0]  truth_table,
    output logic [IDX_W-1:0] fail_idx
);

    if (N_IN != IDX_W) begin : g_bad_n_in
        $error("tt_sweeper supports only N_IN == 4");
    end

    sweep_state_t     state, state_nxt;
    logic [TT_W-1:0]  exp_q;
    logic [IDX_W-1:0] idx;
    logic             fail;
    logic             tc;
    logic             mismatch;
    logic             sweep_end;

    tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .clr    (state != SETTLE),
        .en     (1'b1),
        .tc     (tc)
    );

    assign mismatch = (LEDR != exp_q[idx]);

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    assign sweep_end = (idx == IDX_W'(TT_W - 1)) || mismatch;
`else
    assign sweep_end = (idx == IDX_W'(TT_W - 1));
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (tc) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = sweep_end ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            exp_q       <= '0;
            idx         <= '0;
            fail        <= 1'b0;
            pass        <= 1'b0;
            fail_idx    <= '0;
            truth_table <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q       <= expected;
                        idx         <= '0;
                        fail        <= 1'b0;
                        pass        <= 1'b0;
                        fail_idx    <= '0;
                        truth_table <= '0;
                    end
                end
                SAMPLE: begin
                    truth_table[idx] <= LEDR;
                    // Only the first mismatch is reported.
                    if (mismatch && !fail) begin
                        fail     <= 1'b1;
                        fail_idx <= idx;
                    end
                    if (!sweep_end) begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: pass <= ~fail;
                default: ;
            endcase
        end
    end

    // The switch drive is the current code; it holds the last code after a sweep.
    assign SW   = idx;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tt_sweeper.sv
// tb/tb_tt_sweeper.sv - directed self-checking bench for tt_sweeper
module tb_tt_sweeper;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [15:0] expected;
    logic [3:0]  sw;
    logic        ledr;
    logic        busy, done, pass;
    logic [15:0] truth_table;
    logic [3:0]  fail_idx;
    logic [15:0] fut_mask;

    logic        start2;
    logic [3:0]  sw2;
    logic        busy2, done2, pass2;
    logic [15:0] tt2;
    logic [3:0]  fail_idx2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ledr = fut_mask[sw];

    tt_sweeper #(.SETTLE_CYCLES(4), .N_IN(4)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .start       (start),
        .expected    (expected),
        .SW          (sw),
        .LEDR        (ledr),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .truth_table (truth_table),
        .fail_idx    (fail_idx)
    );

    tt_sweeper #(.SETTLE_CYCLES(1), .N_IN(4)) dut1 (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .start       (start2),
        .expected    (16'hFFFF),
        .SW          (sw2),
        .LEDR        (1'b1),
        .busy        (busy2),
        .done        (done2),
        .pass        (pass2),
        .truth_table (tt2),
        .fail_idx    (fail_idx2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Accept a start at the next edge, then record (in edges after acceptance) the first
    // cycle done is seen and the cycle busy falls. disturb spams start and scrambles expected.
    task automatic run_sweep(input logic [15:0] exp_mask, input bit disturb,
                             output int done_at, output int idle_at);
        int n;
        expected = exp_mask;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        n       = 0;
        done_at = -1;
        idle_at = -1;
        while (n < 200) begin
            if (done && done_at < 0) done_at = n;
            if (!busy) begin
                idle_at = n;
                break;
            end
            if (disturb) begin
                start    = (n % 3 == 0);
                expected = 16'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        start    = 1'b0;
        expected = exp_mask;
    endtask

    initial begin
        int d, i, sw_err, n;
        resetn   = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        expected = 16'h0000;
        fut_mask = 16'h28AE;
        repeat (3) @(negedge clk);

        check("rst_sw", sw, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_tt", truth_table, 16'h0000);
        check("rst_fail_idx", fail_idx, 4'h0);

        resetn = 1'b1;
        @(negedge clk);

        run_sweep(16'h28AE, 1'b0, d, i);
        check("match_done_at", d, 80);
        check("match_len", i, 81);
        check("match_tt", truth_table, 16'h28AE);
        check("match_pass", pass, 1'b1);
        check("match_fail_idx", fail_idx, 4'h0);
        check("match_sw_hold", sw, 4'hF);

        run_sweep(16'h28AF, 1'b0, d, i);
        check("mis0_pass", pass, 1'b0);
        check("mis0_fail_idx", fail_idx, 4'h0);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        check("mis0_len", i, 6);
        check("mis0_tt", truth_table, 16'h0000);
`else
        check("mis0_len", i, 81);
        check("mis0_tt", truth_table, 16'h28AE);
`endif

        run_sweep(16'h28AE, 1'b1, d, i);
        check("dist_done_at", d, 80);
        check("dist_len", i, 81);
        check("dist_tt", truth_table, 16'h28AE);
        check("dist_pass", pass, 1'b1);
        @(negedge clk);
        check("dist_no_requeue", busy, 1'b0);

        // SETTLE_CYCLES=1 instance, FUT tied high
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        sw_err = 0;
        n      = 0;
        while (busy2 && n < 100) begin
            if (n < 32 && sw2 !== 4'(n / 2)) sw_err++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("s1_len", n, 33);
        check("s1_sw_steps", sw_err, 0);
        check("s1_pass", pass2, 1'b1);
        check("s1_tt", tt2, 16'hFFFF);

        // reset in the middle of code 7
        expected = 16'h28AE;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        while (sw !== 4'h7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_code7", sw, 4'h7);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_sw", sw, 4'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tt", truth_table, 16'h0000);
        check("mid_rst_pass", pass, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_sweep(16'h28AE, 1'b0, d, i);
        check("post_rst_len", i, 81);
        check("post_rst_tt", truth_table, 16'h28AE);
        check("post_rst_pass", pass, 1'b1);

        fut_mask = 16'h0004;
        run_sweep(16'h0000, 1'b0, d, i);
        check("m4_fail_idx", fail_idx, 4'h2);
        check("m4_pass", pass, 1'b0);
        check("m4_tt", truth_table, 16'h0004);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        check("m4_len", i, 16);
`else
        check("m4_len", i, 81);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
